// File: rtl/debug_trace_buffer.sv
// rtl/debug_trace_buffer.sv - trace capture buffer with trigger, post-count freeze and opcode shadow
module debug_trace_buffer #(
  parameter int WIDTH      = 32,
  parameter int PC_WIDTH   = 9,
  parameter int DEPTH      = 16,
  parameter int NUM_STAGES = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_debug,
  input  logic                          stall,
  input  logic [PC_WIDTH-1:0]           pc_in,
  input  logic [6:0]                    opcode_in,
  input  logic [WIDTH-1:0]              alu_in,
  input  logic [WIDTH-1:0]              wb_in,
  input  logic                          reg_write_in,
  input  logic                          arm,
  input  logic [1:0]                    trig_mode,
  input  logic [PC_WIDTH-1:0]           trig_pc,
  input  logic [6:0]                    trig_opcode,
  input  logic                          trig_ext,
  input  logic [$clog2(DEPTH):0]        post_count,
  input  logic [$clog2(DEPTH)-1:0]      rd_idx,
  output logic [PC_WIDTH-1:0]           rd_pc,
  output logic [6:0]                    rd_opcode,
  output logic [WIDTH-1:0]              rd_alu,
  output logic [WIDTH-1:0]              rd_wb,
  output logic                          rd_reg_write,
  output logic                          rd_valid,
  output logic [1:0]                    state_out,
  output logic                          trig_fired,
  output logic [$clog2(DEPTH)-1:0]      trig_pos,
  output logic [$clog2(DEPTH):0]        entry_count,
  output logic [NUM_STAGES*7-1:0]       opcode_stage
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = PC_WIDTH + 7 + 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] trig_ptr;
  logic [CW-1:0] remaining;
  logic [RW-1:0] mem [DEPTH];

  logic          cap;
  logic          hit;
  logic [CW-1:0] eff_post;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] rd_word;

  // A full buffer has entry_count[AW-1:0] == 0, so oldest collapses to wr_ptr.
  assign cap      = enable_debug & ~stall & ((state == S_ARMED) | (state == S_POST));
  assign eff_post = (post_count > CW'(DEPTH - 1)) ? CW'(DEPTH - 1) : post_count;
  assign oldest   = wr_ptr - entry_count[AW-1:0];
  assign rd_addr  = oldest + rd_idx;
  assign rd_word  = mem[rd_addr];
  assign state_out = state;

  // Trigger condition for the record presented this cycle
  always_comb begin
    hit = 1'b0;
    case (trig_mode)
      2'd0: hit = 1'b1;
      2'd1: hit = (pc_in == trig_pc);
      2'd2: hit = (opcode_in == trig_opcode);
      2'd3: hit = trig_ext;
      default: hit = 1'b0;
    endcase
  end

  // Trace RAM write; no reset so it maps onto plain memory
  always_ff @(posedge clk) begin
    if (cap && !arm) begin
      mem[wr_ptr] <= {pc_in, opcode_in, alu_in, wb_in, reg_write_in};
    end
  end

  // Capture FSM: arm restarts, trigger starts the post window, DONE freezes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      entry_count <= '0;
      remaining   <= '0;
      trig_fired  <= 1'b0;
      trig_ptr    <= '0;
    end else if (arm) begin
      state       <= S_ARMED;
      wr_ptr      <= '0;
      entry_count <= '0;
      remaining   <= '0;
      trig_fired  <= 1'b0;
    end else if (cap) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (entry_count != CW'(DEPTH)) begin
        entry_count <= entry_count + CW'(1);
      end
      if (state == S_ARMED && hit) begin
        trig_fired <= 1'b1;
        trig_ptr   <= wr_ptr;
        if (eff_post == '0) begin
          state <= S_DONE;
        end else begin
          state     <= S_POST;
          remaining <= eff_post;
        end
      end else if (state == S_POST) begin
        remaining <= remaining - CW'(1);
        if (remaining == CW'(1)) begin
          state <= S_DONE;
        end
      end
    end
  end

  // Registered read port and oldest-relative trigger position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pc        <= '0;
      rd_opcode    <= '0;
      rd_alu       <= '0;
      rd_wb        <= '0;
      rd_reg_write <= 1'b0;
      rd_valid     <= 1'b0;
      trig_pos     <= '0;
    end else begin
      trig_pos <= trig_ptr - oldest;
      if ({1'b0, rd_idx} < entry_count) begin
        {rd_pc, rd_opcode, rd_alu, rd_wb, rd_reg_write} <= rd_word;
        rd_valid <= 1'b1;
      end else begin
        rd_pc        <= '0;
        rd_opcode    <= '0;
        rd_alu       <= '0;
        rd_wb        <= '0;
        rd_reg_write <= 1'b0;
        rd_valid     <= 1'b0;
      end
    end
  end

  // Opcode shadow advances with the pipeline and holds on stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_stage <= '0;
    end else if (!stall) begin
      opcode_stage <= {opcode_stage[NUM_STAGES*7-8:0], opcode_in};
    end
  end

endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb/tb_debug_trace_buffer.sv - randomized and directed bench against a queue-based trace model
module tb_debug_trace_buffer;

  localparam int WIDTH      = 32;
  localparam int PC_WIDTH   = 9;
  localparam int DEPTH      = 16;
  localparam int NUM_STAGES = 5;
  localparam int AW         = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable_debug, stall, reg_write_in, arm, trig_ext;
  logic [PC_WIDTH-1:0]     pc_in, trig_pc;
  logic [6:0]              opcode_in, trig_opcode;
  logic [WIDTH-1:0]        alu_in, wb_in;
  logic [1:0]              trig_mode;
  logic [AW:0]             post_count;
  logic [AW-1:0]           rd_idx;
  logic [PC_WIDTH-1:0]     rd_pc;
  logic [6:0]              rd_opcode;
  logic [WIDTH-1:0]        rd_alu, rd_wb;
  logic                    rd_reg_write, rd_valid, trig_fired;
  logic [1:0]              state_out;
  logic [AW-1:0]           trig_pos;
  logic [AW:0]             entry_count;
  logic [NUM_STAGES*7-1:0] opcode_stage;

  debug_trace_buffer #(.WIDTH(WIDTH), .PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH), .NUM_STAGES(NUM_STAGES)) dut (
    .clk(clk), .reset(reset), .enable_debug(enable_debug), .stall(stall),
    .pc_in(pc_in), .opcode_in(opcode_in), .alu_in(alu_in), .wb_in(wb_in),
    .reg_write_in(reg_write_in), .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc),
    .trig_opcode(trig_opcode), .trig_ext(trig_ext), .post_count(post_count), .rd_idx(rd_idx),
    .rd_pc(rd_pc), .rd_opcode(rd_opcode), .rd_alu(rd_alu), .rd_wb(rd_wb),
    .rd_reg_write(rd_reg_write), .rd_valid(rd_valid), .state_out(state_out),
    .trig_fired(trig_fired), .trig_pos(trig_pos), .entry_count(entry_count),
    .opcode_stage(opcode_stage)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [6:0]          op;
    logic [WIDTH-1:0]    alu;
    logic [WIDTH-1:0]    wb;
    logic                rw;
  } rec_t;

  // Model: trace is a queue of at most DEPTH records, oldest at index 0
  rec_t     q[$];
  int       m_state;
  bit       m_fired;
  int       m_trig_idx;
  int       m_rem;
  logic [6:0] m_shadow [NUM_STAGES];
  rec_t     exp_rd;
  bit       exp_rd_valid;
  int       exp_tp;
  bit       exp_tp_chk;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0; m_fired = 0; m_trig_idx = 0; m_rem = 0;
    for (int k = 0; k < NUM_STAGES; k++) m_shadow[k] = '0;
    exp_rd = '0; exp_rd_valid = 0; exp_tp = 0; exp_tp_chk = 0;
  endtask

  task automatic model_step();
    bit hit;
    int eff;
    rec_t r;
    if (int'(rd_idx) < q.size()) begin
      exp_rd = q[rd_idx]; exp_rd_valid = 1;
    end else begin
      exp_rd = '0; exp_rd_valid = 0;
    end
    exp_tp_chk = m_fired;
    exp_tp     = m_trig_idx;
    if (!stall) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) m_shadow[k] = m_shadow[k-1];
      m_shadow[0] = opcode_in;
    end
    case (trig_mode)
      2'd0: hit = 1;
      2'd1: hit = (pc_in == trig_pc);
      2'd2: hit = (opcode_in == trig_opcode);
      default: hit = trig_ext;
    endcase
    if (arm) begin
      q.delete(); m_state = 1; m_fired = 0; m_rem = 0;
    end else if (enable_debug && !stall && (m_state == 1 || m_state == 2)) begin
      r = '{pc: pc_in, op: opcode_in, alu: alu_in, wb: wb_in, rw: reg_write_in};
      q.push_back(r);
      if (q.size() > DEPTH) begin
        void'(q.pop_front());
        m_trig_idx--;
      end
      if (m_state == 1 && hit) begin
        m_fired = 1;
        m_trig_idx = q.size() - 1;
        eff = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
        if (eff == 0) m_state = 3;
        else begin m_state = 2; m_rem = eff; end
      end else if (m_state == 2) begin
        m_rem--;
        if (m_rem == 0) m_state = 3;
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM_STAGES*7-1:0] e;
    for (int k = 0; k < NUM_STAGES; k++) e[k*7 +: 7] = m_shadow[k];
    check_eq("state_out", 64'(state_out), 64'(m_state));
    check_eq("entry_count", 64'(entry_count), 64'(q.size()));
    check_eq("trig_fired", 64'(trig_fired), 64'(m_fired));
    check_eq("rd_valid", 64'(rd_valid), 64'(exp_rd_valid));
    check_eq("rd_pc", 64'(rd_pc), 64'(exp_rd.pc));
    check_eq("rd_opcode", 64'(rd_opcode), 64'(exp_rd.op));
    check_eq("rd_alu", 64'(rd_alu), 64'(exp_rd.alu));
    check_eq("rd_wb", 64'(rd_wb), 64'(exp_rd.wb));
    check_eq("rd_reg_write", 64'(rd_reg_write), 64'(exp_rd.rw));
    check_eq("opcode_stage", 64'(opcode_stage), 64'(e));
    if (exp_tp_chk) check_eq("trig_pos", 64'(trig_pos), 64'(exp_tp));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_rec(input logic [PC_WIDTH-1:0] pc, input logic [6:0] op);
    pc_in = pc; opcode_in = op;
    alu_in = $urandom; wb_in = $urandom; reg_write_in = 1'($urandom);
  endtask

  task automatic do_arm();
    arm = 1; tick(); arm = 0;
  endtask

  function automatic logic [6:0] rand_op_not33();
    logic [6:0] o;
    o = 7'($urandom);
    if (o == 7'h33) o = 7'h13;
    return o;
  endfunction

  initial begin
    reset = 1; enable_debug = 0; stall = 0; arm = 0; trig_ext = 0;
    trig_mode = 0; trig_pc = 0; trig_opcode = 0; post_count = 0; rd_idx = 0;
    set_rec('0, '0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check_eq("rst_state", 64'(state_out), 64'd0);
    check_eq("rst_entry_count", 64'(entry_count), 64'd0);
    check_eq("rst_trig_fired", 64'(trig_fired), 64'd0);
    check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_opcode_stage", 64'(opcode_stage), 64'd0);
    check_eq("rst_trig_pos", 64'(trig_pos), 64'd0);
    tick();
    check_eq("idle_holds", 64'(state_out), 64'd0);

    // PC-match trigger with two post records
    enable_debug = 1;
    do_arm();
    trig_mode = 2'd1; trig_pc = 9'h010; post_count = 5'd2;
    for (int i = 0; i < 8; i++) begin
      set_rec(PC_WIDTH'(i * 4), 7'($urandom));
      tick();
      if (i == 6) check_eq("pcm_done_after_018", 64'(state_out), 64'd3);
    end
    check_eq("pcm_entry_count", 64'(entry_count), 64'd7);
    rd_idx = 4'd4;
    tick();
    check_eq("pcm_rd_pc", 64'(rd_pc), 64'h010);
    check_eq("pcm_trig_pos", 64'(trig_pos), 64'd4);

    // External mode never fires; stall holds capture; 20 records wrap the buffer
    do_arm();
    trig_mode = 2'd3; trig_ext = 0; rd_idx = 0;
    for (int i = 0; i < 3; i++) begin set_rec(PC_WIDTH'(i), 7'($urandom)); tick(); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin set_rec(PC_WIDTH'(100 + i), 7'($urandom)); tick(); end
    check_eq("stall_entry_count", 64'(entry_count), 64'd3);
    stall = 0;
    for (int i = 3; i < 20; i++) begin set_rec(PC_WIDTH'(i), 7'($urandom)); tick(); end
    check_eq("wrap_entry_count", 64'(entry_count), 64'd16);
    check_eq("wrap_state", 64'(state_out), 64'd1);
    tick();
    check_eq("wrap_oldest_pc", 64'(rd_pc), 64'd4);

    // Opcode match with oversized post_count clamps to DEPTH-1
    do_arm();
    trig_mode = 2'd2; trig_opcode = 7'h33; post_count = 5'd31;
    for (int i = 0; i < 5; i++) begin set_rec(PC_WIDTH'($urandom), rand_op_not33()); tick(); end
    set_rec(9'h1A0, 7'h33); tick();
    for (int i = 0; i < 20; i++) begin set_rec(PC_WIDTH'($urandom), rand_op_not33()); tick(); end
    check_eq("opm_state", 64'(state_out), 64'd3);
    check_eq("opm_entry_count", 64'(entry_count), 64'd16);
    tick();
    check_eq("opm_trig_pos", 64'(trig_pos), 64'd0);
    check_eq("opm_oldest_pc", 64'(rd_pc), 64'h1A0);

    // Re-arm while in POST
    do_arm();
    trig_mode = 2'd0; post_count = 5'd10;
    for (int i = 0; i < 3; i++) begin set_rec(PC_WIDTH'(i), 7'($urandom)); tick(); end
    check_eq("post_state", 64'(state_out), 64'd2);
    do_arm();
    check_eq("rearm_state", 64'(state_out), 64'd1);
    check_eq("rearm_entry_count", 64'(entry_count), 64'd0);
    check_eq("rearm_trig_fired", 64'(trig_fired), 64'd0);
    rd_idx = 0; enable_debug = 0;
    tick();
    check_eq("rearm_rd_valid", 64'(rd_valid), 64'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      arm          = ($urandom_range(0, 39) == 0);
      enable_debug = ($urandom_range(0, 7) != 0);
      stall        = ($urandom_range(0, 4) == 0);
      if (arm) begin
        trig_mode   = 2'($urandom);
        trig_pc     = PC_WIDTH'($urandom_range(0, 7) * 4);
        trig_opcode = 7'($urandom_range(0, 7));
        post_count  = 5'($urandom);
      end
      trig_ext = ($urandom_range(0, 15) == 0);
      rd_idx   = 4'($urandom);
      set_rec(PC_WIDTH'($urandom_range(0, 7) * 4), 7'($urandom_range(0, 7)));
      tick();
    end

    // Asynchronous reset in the middle of POST
    arm = 0; stall = 0; enable_debug = 1;
    do_arm();
    trig_mode = 2'd0; post_count = 5'd10;
    for (int i = 0; i < 5; i++) begin set_rec(PC_WIDTH'(i), 7'($urandom)); tick(); end
    check_eq("pre_rst_entry_count", 64'(entry_count), 64'd5);
    check_eq("pre_rst_state", 64'(state_out), 64'd2);
    #2 reset = 1;
    #1 check_eq("async_rst_state", 64'(state_out), 64'd0);
    @(posedge clk);
    #1 reset = 0;
    model_reset();
    enable_debug = 0; set_rec('0, '0); rd_idx = 0;
    tick();
    check_eq("post_rst_state", 64'(state_out), 64'd0);
    check_eq("post_rst_entry_count", 64'(entry_count), 64'd0);
    check_eq("post_rst_trig_fired", 64'(trig_fired), 64'd0);
    check_eq("post_rst_rd_valid", 64'(rd_valid), 64'd0);
    check_eq("post_rst_opcode_stage", 64'(opcode_stage), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_trace_buffer.md
Name: debug_trace_buffer

Overview:
- Parametrised trace and trigger unit for the pipelined RISC-V backend.
- Captures per-cycle execution records (PC, opcode, ALU result, write-back data, reg-write flag) into a circular buffer while armed.
- Freezes after a programmable trigger plus post-trigger count; the user then reads the frozen trace by index.
- Also keeps a stall-aware opcode shadow of every pipeline stage for live observation.

Parameters:
- WIDTH, 32, datapath width of ALU result and write-back data
- PC_WIDTH, 9, program counter width
- DEPTH, 16, trace entries; power of 2, >= 2
- NUM_STAGES, 5, opcode shadow stages (fetch..write-back)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- enable_debug  in  1  global capture enable from user
- stall  in  1  pipeline stall; blocks capture and shadow shift
- pc_in  in  PC_WIDTH  PC of instruction being traced
- opcode_in  in  7  opcode entering fetch
- alu_in  in  WIDTH  ALU result
- wb_in  in  WIDTH  write-back data
- reg_write_in  in  1  register-file write enable
- arm  in  1  pulse: clear buffer and start capture
- trig_mode  in  2  0 immediate, 1 PC match, 2 opcode match, 3 external
- trig_pc  in  PC_WIDTH  PC compare value
- trig_opcode  in  7  opcode compare value
- trig_ext  in  1  external trigger
- post_count  in  $clog2(DEPTH)+1  records captured after trigger record
- rd_idx  in  $clog2(DEPTH)  read index, 0 = oldest record
- rd_pc  out  PC_WIDTH  read record PC
- rd_opcode  out  7  read record opcode
- rd_alu  out  WIDTH  read record ALU result
- rd_wb  out  WIDTH  read record write-back data
- rd_reg_write  out  1  read record reg-write flag
- rd_valid  out  1  rd_idx addressed a stored record
- state_out  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- trig_fired  out  1  trigger occurred since last arm
- trig_pos  out  $clog2(DEPTH)  oldest-relative index of trigger record, valid in DONE
- entry_count  out  $clog2(DEPTH)+1  stored records, saturates at DEPTH
- opcode_stage  out  NUM_STAGES*7  shadow opcodes; bits [6:0] = fetch

Behaviour:
- Reset (async, active-high): state IDLE; wr_ptr, entry_count, remaining, trig_fired, trig_pos 0; all rd_* outputs 0; opcode_stage all 0. Buffer RAM is not reset.
- Capture condition: cap = enable_debug & ~stall & (state ARMED or POST). On cap, the record {pc_in, opcode_in, alu_in, wb_in, reg_write_in} is written at wr_ptr; wr_ptr increments mod DEPTH; entry_count increments, saturating at DEPTH. When full, the oldest record is overwritten.
- Trigger hit, evaluated only in ARMED on cap cycles:
  - mode 0: always hits.
  - mode 1: pc_in == trig_pc.
  - mode 2: opcode_in == trig_opcode.
  - mode 3: trig_ext.
- On a hit:
  - The hit record is written.
  - trig_fired <= 1.
  - trig_ptr <= wr_ptr (physical index).
  - Next state is DONE if eff_post == 0; otherwise POST with remaining <= eff_post.
  - eff_post = min(post_count, DEPTH-1), so the trigger record is never overwritten.
- POST: each cap decrements remaining. The cap that brings remaining from 1 to 0 moves the state to DONE (same edge).
- DONE: no writes; contents frozen until the next arm.
- arm, highest priority, any state:
  - next state ARMED.
  - wr_ptr, entry_count, trig_fired, remaining cleared.
  - No capture on the arm cycle.
- Without arm, IDLE holds.
- Read path, 1-cycle latency:
  - Physical address = (wr_ptr - entry_count + rd_idx) mod DEPTH.
  - rd_* register that record; rd_valid <= 1 when rd_idx < entry_count.
  - Otherwise rd_* <= 0 and rd_valid <= 0.
  - Reads are allowed in any state. A read concurrent with a write to the same address returns the old data.
- trig_pos = (trig_ptr - (wr_ptr - entry_count)) mod DEPTH, registered, updated every cycle.
- Opcode shadow: when ~stall, stage0 <= opcode_in and stage k <= stage k-1. It holds under stall. It is independent of state and enable_debug.
- All outputs are registered; no combinational paths from inputs to outputs.

Test Plan:
- Reset mid-POST (entry_count=5), then release -> next cycle state_out=0, entry_count=0, trig_fired=0, rd_valid=0, opcode_stage=0.
- arm, trig_mode=1, trig_pc=0x010, post_count=2, PCs 0x000,0x004..0x01C one per cycle -> DONE after PC 0x018 captured; entry_count=7, trig_pos=4, rd_idx=4 gives rd_pc=0x010 one cycle later.
- arm, trig_mode=3, no trigger for 20 cycles with PCs 0..19, DEPTH=16 -> entry_count=16, state ARMED, rd_idx=0 gives rd_pc=4 (wrap overwrote 0..3).
- ARMED with stall=1 for 3 cycles while PC changes -> entry_count unchanged, opcode_stage frozen; stall=0 -> capture and shift resume.
- trig_mode=2, trig_opcode=0x33, post_count=31 (> DEPTH-1) -> exactly 15 post records, trigger record kept at trig_pos=0, entry_count=16.
- arm asserted while in POST -> next cycle state ARMED, entry_count=0, trig_fired=0; rd_idx=0 gives rd_valid=0.
